instruction_fetch_stage: RTL and testbench

INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

---
 rtl/instruction_fetch_stage.sv | 144 ++++++++++++++
 tb/tb_instruction_fetch_stage.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// ============================================================================
// Module   : instruction_fetch_stage
// Purpose  : Pipeline instruction fetch stage. Keeps the PC, issues word
//            requests to instruction memory, buffers one instruction while
//            decode stalls, and drops a stale outstanding request after a
//            redirect.
// Ports    : Clk, Reset           - clock, synchronous active-high reset
//            Stall                - decode cannot accept this cycle
//            Redirect, RedirectTarget - taken branch/jump (one-cycle pulse)
//            IMemReq, IMemAddr    - instruction memory request / address
//            IMemAck, IMemRdata   - memory completion / returned word
//            PCF, PCPlus4F        - PC of offered instruction and PC+4
//            InstructionF         - instruction offered to IF/ID
//            Fetch_Enable, FlushD - IF/ID load and clear strobes
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemRdata,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic [31:0] InstructionF,
  output logic        Fetch_Enable,
  output logic        FlushD
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,   // request outstanding at pc_q
    S_HOLD  = 2'd1,   // instruction buffered, waiting for Stall to drop
    S_DRAIN = 2'd2    // stale request outstanding, data will be dropped
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] ibuf_q, ibuf_d;

  logic [31:0] w_target;
  logic        w_unused_tgt_lo;

  // Low target bits are forced to zero so every fetch stays word aligned.
  assign w_target        = {RedirectTarget[31:2], 2'b00};
  assign w_unused_tgt_lo = ^RedirectTarget[1:0];

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign IMemReq  = !Reset && (state_q != S_HOLD);
  assign IMemAddr = pc_q;
  assign PCF      = pc_q;
  assign PCPlus4F = pc_q + 32'd4;
  assign FlushD   = !Reset && Redirect;

  assign Fetch_Enable = !Reset && !Redirect && !Stall &&
                        (((state_q == S_FETCH) && IMemAck) || (state_q == S_HOLD));

  always_comb begin
    InstructionF = NOP_INSTR;
    if ((state_q == S_FETCH) && IMemAck) begin
      InstructionF = IMemRdata;
    end else if (state_q == S_HOLD) begin
      InstructionF = ibuf_q;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Redirect outranks ack and stall in every state.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    ibuf_d  = ibuf_q;
    unique case (state_q)
      S_FETCH: begin
        if (Redirect) begin
          if (IMemAck) begin
            pc_d    = w_target;
          end else begin
            // Keep the address stable until memory completes the old request.
            pend_d  = w_target;
            state_d = S_DRAIN;
          end
        end else if (IMemAck) begin
          if (Stall) begin
            ibuf_d  = IMemRdata;
            state_d = S_HOLD;
          end else begin
            pc_d    = pc_q + 32'd4;
          end
        end
      end
      S_HOLD: begin
        if (Redirect) begin
          pc_d    = w_target;
          state_d = S_FETCH;
        end else if (!Stall) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (IMemAck) begin
          pc_d    = Redirect ? w_target : pend_q;
          state_d = S_FETCH;
        end else if (Redirect) begin
          pend_d  = w_target;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      pend_q  <= 32'h0000_0000;
      ibuf_q  <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      ibuf_q  <= ibuf_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
// ============================================================================
// Module   : tb_instruction_fetch_stage
// Purpose  : Self-checking bench for instruction_fetch_stage. Directed
//            scenarios followed by randomized traffic, all compared against
//            a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_stage;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] C_NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redir;
  logic [31:0] tgt;
  logic        ack;
  logic [31:0] rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pcf;
  logic [31:0] pcp4;
  logic [31:0] instr;
  logic        fetch_en;
  logic        flush;

  int n_cmp = 0;
  int n_err = 0;

  instruction_fetch_stage #(
    .RESET_PC  (C_RESET_PC),
    .NOP_INSTR (C_NOP)
  ) u_dut (
    .Clk            (clk),
    .Reset          (rst),
    .Stall          (stall),
    .Redirect       (redir),
    .RedirectTarget (tgt),
    .IMemReq        (imem_req),
    .IMemAddr       (imem_addr),
    .IMemAck        (ack),
    .IMemRdata      (rdata),
    .PCF            (pcf),
    .PCPlus4F       (pcp4),
    .InstructionF   (instr),
    .Fetch_Enable   (fetch_en),
    .FlushD         (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model: the PC of the next instruction to deliver, an optional
  // buffered word, and an optional "redirect remembered until the stale
  // request completes" target.
  // --------------------------------------------------------------------------
  logic [31:0] m_pc      = C_RESET_PC;
  logic        m_have    = 1'b0;   // an instruction is parked for decode
  logic [31:0] m_word    = C_NOP;
  logic        m_stale   = 1'b0;   // outstanding request belongs to a dead path
  logic [31:0] m_pend    = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare every output with the model, advance.
  task automatic cycle(input logic i_rst, input logic i_stall, input logic i_redir,
                       input logic [31:0] i_tgt, input logic i_ack, input logic [31:0] i_data);
    logic        e_req;
    logic        e_fe;
    logic        delivered;
    logic [31:0] e_instr;
    logic [31:0] aligned;
    @(negedge clk);
    rst   = i_rst;
    stall = i_stall;
    redir = i_redir;
    tgt   = i_tgt;
    ack   = i_ack;
    rdata = i_data;
    #1;
    aligned   = i_tgt & 32'hFFFF_FFFC;
    delivered = !m_have && !m_stale && i_ack;   // fresh word arrives now
    e_req     = !i_rst && !m_have;
    e_fe      = !i_rst && !i_redir && !i_stall && (m_have || delivered);
    e_instr   = m_have ? m_word : (delivered ? i_data : C_NOP);
    check("IMemReq",      {31'b0, imem_req}, {31'b0, e_req});
    check("IMemAddr",     imem_addr, m_pc);
    check("PCF",          pcf, m_pc);
    check("PCPlus4F",     pcp4, m_pc + 32'd4);
    check("Fetch_Enable", {31'b0, fetch_en}, {31'b0, e_fe});
    check("FlushD",       {31'b0, flush}, {31'b0, !i_rst && i_redir});
    if (!i_rst) check("InstructionF", instr, e_instr);
    @(posedge clk);
    if (i_rst) begin
      m_pc = C_RESET_PC; m_have = 1'b0; m_stale = 1'b0; m_pend = 32'h0; m_word = C_NOP;
    end else if (i_redir) begin
      if (m_have || i_ack) begin
        // Nothing outstanding (or it completes now): jump immediately.
        m_pc = aligned; m_have = 1'b0; m_stale = 1'b0;
      end else begin
        m_pend = aligned; m_stale = 1'b1;
      end
    end else if (m_stale) begin
      if (i_ack) begin
        m_pc = m_pend; m_stale = 1'b0;
      end
    end else if (e_fe) begin
      m_pc = m_pc + 32'd4; m_have = 1'b0;
    end else if (delivered && i_stall) begin
      m_word = i_data; m_have = 1'b1;
    end
    #1;
  endtask

  initial begin
    logic r_ack;
    rst = 1'b1; stall = 1'b0; redir = 1'b0; tgt = 32'h0; ack = 1'b0; rdata = 32'h0;

    // Reset, with a spurious ack that must be ignored.
    cycle(1, 0, 0, 32'h0, 1, 32'hDEAD_BEEF);
    cycle(1, 1, 1, 32'h1234, 1, 32'hDEAD_BEEF);
    check("reset_pc", pcf, C_RESET_PC);

    // Zero-wait streaming, data = address: 0,4,8,C.
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 32'h0, 1, 32'(i * 4));
    check("stream_addr", imem_addr, 32'h10);

    // Ack at 0x10 under Stall, then two more stalled cycles.
    cycle(0, 1, 0, 32'h0, 1, 32'h0000_0010);
    cycle(0, 1, 0, 32'h0, 0, 32'h0);
    cycle(0, 1, 0, 32'h0, 0, 32'h0);
    check("hold_req",   {31'b0, imem_req}, 32'h0);
    check("hold_instr", instr, 32'h0000_0010);
    check("hold_pc",    pcf, 32'h10);
    cycle(0, 0, 0, 32'h0, 0, 32'h0);
    check("hold_release_addr", imem_addr, 32'h14);

    // Jump to 0x40, then redirect to 0x203 while 0x40 is still outstanding.
    cycle(0, 0, 1, 32'h40, 1, 32'h0);
    cycle(0, 0, 1, 32'h203, 0, 32'h0);
    check("drain_addr_held0", imem_addr, 32'h40);
    cycle(0, 0, 0, 32'h0, 0, 32'h0);
    check("drain_addr_held1", imem_addr, 32'h40);
    cycle(0, 0, 0, 32'h0, 1, 32'hBAD0_0040);
    check("drain_target", imem_addr, 32'h200);

    // Redirect coincident with ack and Stall.
    cycle(0, 1, 1, 32'h80, 1, 32'h1111_1111);
    check("redir_ack_addr", imem_addr, 32'h80);
    check("redir_ack_req",  {31'b0, imem_req}, 32'h1);

    // PC wrap at the top of the address space.
    cycle(0, 0, 1, 32'hFFFF_FFFF, 1, 32'h2222_2222);
    check("wrap_pc",    pcf, 32'hFFFF_FFFC);
    check("wrap_plus4", pcp4, 32'h0);
    cycle(0, 0, 0, 32'h0, 1, 32'h3333_3333);
    check("wrap_next", imem_addr, 32'h0);

    // Reset during an outstanding request, then refetch from RESET_PC.
    cycle(0, 0, 0, 32'h0, 0, 32'h0);
    cycle(1, 0, 0, 32'h0, 1, 32'h4444_4444);
    check("reset_req_low", {31'b0, imem_req}, 32'h0);
    cycle(0, 0, 0, 32'h0, 0, 32'h0);
    check("reset_refetch", imem_addr, C_RESET_PC);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r_ack = !m_have && ($urandom_range(0, 2) != 0);
      cycle(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 7) == 0),
            $urandom,
            r_ack,
            $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
